// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: valid/ready wrapper and flush sequencer for a stall-free pipelined IFFT core
// Optional stall counter built when FFTSEQ_STALL_COUNT_EN is defined.
module fft_frame_sequencer #(
  parameter int IW = 16,
  parameter int OW = 21,
  parameter int LGSIZE = 8,
  parameter int FCW = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [2*IW-1:0]   i_s_data,
  input  logic              i_flush,
  output logic              o_fft_ce,
  output logic [2*IW-1:0]   o_fft_sample,
  input  logic [2*OW-1:0]   i_fft_result,
  input  logic              i_fft_sync,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [2*OW-1:0]   o_m_data,
  output logic              o_m_first,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_flush_done,
  output logic [FCW-1:0]    o_frames_in,
  output logic [FCW-1:0]    o_frames_out,
  output logic [31:0]       o_stall_count
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic pend, started, pad, xfer, last_xfer, flush_end, wrap;
  logic [LGSIZE-1:0] in_idx, out_idx;
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (o_fft_ce ? RUN : IDLE) :
              state == RUN  ? (i_flush ? FLUSH : RUN) :
                              (flush_end ? IDLE : FLUSH);
  end
  // the core is frozen on the final transfer so no post-frame sample leaks out on exit
  always_comb begin
    o_m_valid = pend && (started || i_fft_sync);
    xfer = o_m_valid && i_m_ready;
    o_m_first = o_m_valid && i_fft_sync;
    o_m_last = o_m_valid && &out_idx;
    last_xfer = xfer && &out_idx;
    flush_end = state == FLUSH && !pad &&
                (o_frames_out == o_frames_in || (last_xfer && o_frames_out + FCW'(1) == o_frames_in));
    o_fft_ce = (state == FLUSH || i_s_valid) && (!pend || i_m_ready) && !flush_end;
    o_s_ready = o_fft_ce && state != FLUSH;
    o_fft_sample = state == FLUSH ? '0 : i_s_data;
    o_m_data = i_fft_result;
    o_busy = state != IDLE;
    wrap = o_fft_ce && &in_idx;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend <= 1'b0;
      started <= 1'b0;
      pad <= 1'b0;
      in_idx <= '0;
      out_idx <= '0;
      o_frames_in <= '0;
      o_frames_out <= '0;
      o_flush_done <= 1'b0;
    end else begin
      pend <= !flush_end && (o_fft_ce || (o_m_valid && !i_m_ready));
      if (pend && i_fft_sync) started <= 1'b1;
      if (flush_end) in_idx <= '0;
      else if (o_fft_ce) in_idx <= in_idx + LGSIZE'(1);
      if (wrap && (state != FLUSH || pad)) o_frames_in <= o_frames_in + FCW'(1);
      if (state == RUN && i_flush) pad <= (in_idx + LGSIZE'(o_fft_ce)) != '0;
      else if (wrap) pad <= 1'b0;
      if (xfer) out_idx <= i_fft_sync ? LGSIZE'(1) : out_idx + LGSIZE'(1);
      if (last_xfer) o_frames_out <= o_frames_out + FCW'(1);
      o_flush_done <= flush_end || (state == IDLE && i_flush);
    end
  end
`ifdef FFTSEQ_STALL_COUNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) stall_q <= '0;
    else if (state != FLUSH && i_s_valid && !o_s_ready && ~&stall_q) stall_q <= stall_q + 32'd1;
  end
  assign o_stall_count = stall_q;
`else
  assign o_stall_count = '0;
`endif
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Flow-control sequencer that sits in front of and behind the 256-point pipelined IFFT core, which has no stall port.
- Converts a valid/ready sample stream into the core's single clock-enable.
- Discards pre-sync garbage on the output side and frames the results with first/last markers.
- On request, flushes the pipeline with zero padding so every accepted frame emerges.

Parameters:
- IW, 16, input component width (core input is 2*IW bits)
- OW, 21, output component width (core output is 2*OW bits)
- LGSIZE, 8, log2 of FFT length (N = 256)
- FCW, 16, width of the frame counters

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_s_valid  in  1  input sample valid
- o_s_ready  out  1  input sample accepted this cycle when high together with i_s_valid
- i_s_data  in  2*IW  input sample {real, imag}
- i_flush  in  1  single-cycle flush request
- o_fft_ce  out  1  clock enable to the core
- o_fft_sample  out  2*IW  sample to the core
- i_fft_result  in  2*OW  core output
- i_fft_sync  in  1  core first-sample marker
- o_m_valid  out  1  output sample valid
- i_m_ready  in  1  downstream ready
- o_m_data  out  2*OW  output sample
- o_m_first  out  1  first bin of output frame
- o_m_last  out  1  bin N-1 of output frame
- o_busy  out  1  state != IDLE
- o_flush_done  out  1  one-cycle pulse at flush completion
- o_frames_in  out  FCW  completed input frames, including the padded one
- o_frames_out  out  FCW  completed output frames
- o_stall_count  out  32  see Optional Feature

Behaviour:
- Reset values:
  - State IDLE; all flags and counters 0.
  - o_m_valid=0, o_fft_ce=0, o_flush_done=0.
  - pend=0, started=0.
- Advance rule:
  - src = i_s_valid in IDLE/RUN; src = 1 in FLUSH.
  - adv = src && (!pend || i_m_ready).
  - o_fft_ce = adv, combinational. o_s_ready = adv && state != FLUSH.
  - o_fft_sample = i_s_data in IDLE/RUN, 0 in FLUSH.
  - In_idx (LGSIZE bits) increments on each adv and wraps N-1 -> 0. The wrap increments o_frames_in, except for zero-fill beyond the padding boundary in FLUSH.
- Output tracking:
  - pend is set the cycle after adv and cleared when (o_m_valid && i_m_ready && !adv).
  - o_m_data = i_fft_result.
  - started is set on the first cycle pend && i_fft_sync; it never clears except by reset.
  - o_m_valid = pend && (started || i_fft_sync).
  - pend && !o_m_valid means a pre-sync sample: discarded silently and pend cleared.
- Output framing:
  - out_idx clears to 1 when a sync sample is accepted, and increments on each accepted transfer otherwise.
  - o_m_first = o_m_valid && i_fft_sync.
  - o_m_last = o_m_valid && out_idx == N-1; o_frames_out increments on that transfer.
- States:
  - IDLE -> RUN on the first adv.
  - RUN -> FLUSH on i_flush. If in_idx==0 and no frame is partial, padding is skipped.
  - FLUSH: feeds zeros to the frame boundary (padding counted toward o_frames_in), then keeps feeding zeros until o_frames_out == o_frames_in.
  - FLUSH exit: -> IDLE with o_flush_done=1 for one cycle; in_idx stays 0; started is preserved.
  - i_flush in IDLE: immediate o_flush_done pulse.
  - i_flush in FLUSH: ignored.
- Simultaneous events: i_flush on the same cycle as an accepted sample — the sample is taken, then FLUSH starts the next cycle.
- Counters wrap modulo 2^FCW. The equality compare is still valid because the difference never exceeds 3.
- Reset mid-operation: all state clears in one cycle. The core must share i_reset.
- Latency: output sample follows its enabling adv by exactly one cycle, when not discarded.

Optional Feature:
- Macro FFTSEQ_STALL_COUNT_EN.
- When defined: o_stall_count counts cycles with i_s_valid && !o_s_ready in IDLE/RUN. It saturates at 2^32-1 and is cleared by reset.
- When undefined: o_stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Continuous stream, i_m_ready=1, 3 frames of impulses (sample 0 = 16'h4000) then flush:
  - outputs are exactly 3*256 samples, first/last at bins 0/255;
  - o_frames_out=3; o_flush_done pulses once; o_busy returns to 0.
- Random i_m_ready at 50% duty during a steady stream:
  - o_fft_ce never asserts while o_m_valid && !i_m_ready;
  - output data is bit-identical to the run with i_m_ready=1.
- Partial frame (100 samples), then i_flush:
  - 156 zero pads are issued; o_frames_in=1 after padding;
  - exactly one 256-bin output frame; done pulse.
- Pre-sync discard: stream with i_m_ready=1 from reset:
  - no o_m_valid before the first i_fft_sync;
  - first o_m_valid coincides with o_m_first=1.
- Reset asserted mid-frame (sample 77):
  - next cycle all outputs equal their reset values;
  - a fresh stream restarts correctly.
- FFTSEQ_STALL_COUNT_EN defined: hold i_m_ready=0 for 40 cycles with i_s_valid=1 -> o_stall_count=40 (within ±1 for the pend transition); with the macro undefined it reads 0.
